// File: rtl/sp_ram_ctrl.sv
// sp_ram_ctrl: parametrised single-port synchronous RAM for CNN feature-map and
// weight buffers. It supports byte-enabled writes, a req/ready/rvalid handshake,
// an optional output register, and a clear engine that zeroes the whole array
// after reset.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | clear engine writes one zero word per cycle; busy=1, ready=0
// ST_RUN   | normal operation; ready=1, one access per cycle
module sp_ram_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1 << ADDR_W,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0,
  parameter int CLEAR_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic                  ready,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic                  busy
);

  localparam int BE_W = DATA_W / 8;
  // The pointer is one bit wider than the address, so DEPTH = 2**ADDR_W fits without wrapping.
  localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W:0]     clr_ptr, clr_ptr_nxt;
  logic                clr_we;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                acc_wr, acc_rd, in_range;
  logic [DATA_W-1:0]   bit_mask, old_word, merged_word, port_word;
  logic                rd1_valid;
  logic [DATA_W-1:0]   rd1_data;

  // State register and clear pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Next-state, clear sequencing and handshake outputs
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    clr_we      = 1'b0;
    ready       = 1'b0;
    busy        = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (clr_ptr == LAST_PTR) begin
          state_nxt   = ST_RUN;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + 1'b1;
        end
      end
      ST_RUN: begin
        ready = 1'b1;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  assign acc_wr   = req & ready & we;
  assign acc_rd   = req & ready & ~we;
  assign in_range = ({1'b0, addr} < DEPTH_W);

  // The byte-enable mask is applied only on writes, so on a read the merged word equals the stored word.
  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < BE_W; i++) begin
      bit_mask[8*i +: 8] = {8{we & be[i]}};
    end
  end

  // Read-modify view of the addressed word. Out-of-range addresses read as zero.
  always_comb begin
    old_word    = in_range ? mem[addr] : '0;
    merged_word = (old_word & ~bit_mask) | (wdata & bit_mask);
    port_word   = (RDW_MODE == 0) ? merged_word : old_word;
  end

  // Array write port: the clear engine has priority. The array itself has no reset.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ptr[ADDR_W-1:0]] <= '0;
    end else if (acc_wr && in_range) begin
      mem[addr] <= merged_word;
    end
  end

  // First read stage: data is captured at the accepting edge and held between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_valid <= 1'b0;
      rd1_data  <= '0;
    end else begin
      rd1_valid <= acc_rd;
      if (acc_rd) rd1_data <= port_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              rd2_valid;
      logic [DATA_W-1:0] rd2_data;

      // Optional output pipeline stage that adds one cycle of read latency
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd2_valid <= 1'b0;
          rd2_data  <= '0;
        end else begin
          rd2_valid <= rd1_valid;
          if (rd1_valid) rd2_data <= rd1_data;
        end
      end

      assign rvalid = rd2_valid;
      assign rdata  = rd2_data;
    end else begin : g_no_out_reg
      assign rvalid = rd1_valid;
      assign rdata  = rd1_data;
    end
  endgenerate

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// tb_sp_ram_ctrl: directed bench that drives two instances from shared inputs.
// dut_a: 16 words, latency 1, RDW_MODE 0.
// dut_b: 12 words, latency 2, RDW_MODE 1.
module tb_sp_ram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req, we;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  be;

  logic        ready_a, rvalid_a, busy_a;
  logic [15:0] rdata_a;
  logic        ready_b, rvalid_b, busy_b;
  logic [15:0] rdata_b;

  int total = 0;
  int bad   = 0;

  sp_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RDW_MODE(0), .OUT_REG(0), .CLEAR_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready_a), .rdata(rdata_a), .rvalid(rvalid_a), .busy(busy_a)
  );

  sp_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .RDW_MODE(1), .OUT_REG(1), .CLEAR_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready_b), .rdata(rdata_b), .rvalid(rvalid_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after rst_n rises. Pulses reads during the clear, counts busy cycles,
  // finds the edge at which each instance becomes ready, and counts any rvalid.
  task automatic wait_clear(input string tag);
    int busy_cnt = 0, first_a = 0, first_b = 0, rv_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      req  = (i <= 11) ? i[0] : 1'b0;
      we   = 1'b0;
      addr = i[3:0];
      if (busy_a) busy_cnt++;
      tick();
      rv_cnt += int'(rvalid_a) + int'(rvalid_b);
      if (first_a == 0 && ready_a) first_a = i;
      if (first_b == 0 && ready_b) first_b = i;
    end
    req = 1'b0;
    chk({tag, "_busy_cycles_a"}, busy_cnt, 16);
    chk({tag, "_ready_edge_a"}, first_a, 16);
    chk({tag, "_ready_edge_b"}, first_b, 12);
    chk({tag, "_no_rvalid"}, rv_cnt, 0);
    chk({tag, "_busy_end"}, {busy_a, busy_b}, 2'b00);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    tick();
    req = 1'b0; we = 1'b0;
    chk($sformatf("wr%0d_no_rvalid", a), {rvalid_a, rvalid_b}, 2'b00);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [15:0] exp_a, input logic [15:0] exp_b);
    req = 1'b1; we = 1'b0; addr = a; be = 2'b11; wdata = 16'h0;
    tick();
    req = 1'b0;
    chk($sformatf("rd%0d_a_rvalid_l1", a), {rvalid_a, rvalid_b}, 2'b10);
    chk($sformatf("rd%0d_a_data", a), rdata_a, exp_a);
    tick();
    chk($sformatf("rd%0d_b_rvalid_l2", a), {rvalid_a, rvalid_b}, 2'b01);
    chk($sformatf("rd%0d_b_data", a), rdata_b, exp_b);
  endtask

  logic [15:0] exp_seq [3];

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    tick(); tick();
    chk("rst_outs_a", {busy_a, ready_a, rvalid_a}, 3'b100);
    chk("rst_outs_b", {busy_b, ready_b, rvalid_b}, 3'b100);
    chk("rst_rdata", {rdata_a, rdata_b}, 32'h0);

    // T1: clear timing, then every word reads back as zero
    rst_n = 1'b1;
    wait_clear("t1");
    for (int i = 0; i < 16; i++) do_read(4'(i), 16'h0000, 16'h0000);

    // T2: full write, then a low-byte merge
    do_write(4'd3, 16'hBEEF, 2'b11);
    do_write(4'd3, 16'h1234, 2'b01);
    do_read(4'd3, 16'hBE34, 16'hBE34);

    // T3: read right after a write to the same address, then back-to-back reads
    do_write(4'd7, 16'hA5A5, 2'b11);
    do_read(4'd7, 16'hA5A5, 16'hA5A5);
    exp_seq[0] = 16'h0000; exp_seq[1] = 16'h0000; exp_seq[2] = 16'hBE34;
    for (int k = 0; k < 5; k++) begin
      req = (k < 3); we = 1'b0; addr = 4'(k + 1);
      tick();
      chk($sformatf("b2b_a_rvalid_%0d", k), rvalid_a, (k < 3));
      if (k < 3) chk($sformatf("b2b_a_data_%0d", k), rdata_a, exp_seq[k]);
      chk($sformatf("b2b_b_rvalid_%0d", k), rvalid_b, (k >= 1 && k <= 3));
      if (k >= 1 && k <= 3) chk($sformatf("b2b_b_data_%0d", k), rdata_b, exp_seq[k-1]);
    end
    req = 1'b0;
    // A write leaves rdata unchanged; a write with be=0 changes nothing
    do_write(4'd5, 16'h5555, 2'b11);
    chk("rdata_hold", {rdata_a, rdata_b}, {16'hBE34, 16'hBE34});
    do_write(4'd7, 16'h9999, 2'b00);
    do_read(4'd7, 16'hA5A5, 16'hA5A5);

    // T4: address 13 is in range for A and out of range for B (DEPTH=12)
    do_write(4'd13, 16'hFFFF, 2'b11);
    do_read(4'd13, 16'hFFFF, 16'h0000);
    do_read(4'd11, 16'h0000, 16'h0000);

    // T5: reset partway through a clear restarts it
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("t5_mid_rst_busy", {busy_a, ready_a, busy_b, ready_b}, 4'b1010);
    tick();
    rst_n = 1'b1;
    wait_clear("t5");
    do_read(4'd7, 16'h0000, 16'h0000);

    // T6: a read in flight when reset asserts is dropped
    do_write(4'd7, 16'hA5A5, 2'b11);
    do_read(4'd7, 16'hA5A5, 16'hA5A5);
    req = 1'b1; we = 1'b0; addr = 4'd7;
    tick();
    req = 1'b0;
    chk("t6_a_rvalid", rvalid_a, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rdata_rst", {rdata_a, rdata_b}, 32'h0);
    begin
      int rv = 0;
      for (int i = 0; i < 3; i++) begin
        tick();
        rv += int'(rvalid_a) + int'(rvalid_b);
      end
      chk("t6_no_rvalid", rv, 0);
    end
    rst_n = 1'b1;
    wait_clear("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
